dcache_assoc: RTL and testbench
===============================

Name: dcache_assoc

Overview:
- Parametrised write-back, write-allocate data cache between the datapath's data-memory request port and the memory controller's data port.
- Generalises the single-shape dcache to configurable sets, ways and words per block, with per-set round-robin replacement.
- Adds a halt-driven flush that writes all dirty blocks back before asserting flushed.

Parameters:
SETS, 8, number of sets; power of 2, ≥2
WAYS, 2, associativity; power of 2, 1..4
BLOCK_WORDS, 2, 32-bit words per block; power of 2, 1..4
HITCNT_ADDR, 32'h00003100, memory address for hit-count store (optional feature only)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous active-high reset
halt  in  1  datapath halted; start flush
dmemREN  in  1  datapath load request
dmemWEN  in  1  datapath store request
dmemaddr  in  32  datapath byte address, word aligned
dmemstore  in  32  store data
dhit  out  1  request satisfied this cycle
dmemload  out  32  load data, valid when dhit
flushed  out  1  flush complete, sticky
dREN  out  1  memory read request
dWEN  out  1  memory write request
daddr  out  32  memory word address
dstore  out  32  memory write data
dload  in  32  memory read data
dwait  in  1  memory busy; access completes in a cycle with dwait=0

Behaviour:
- Address split: [1:0] byte offset, ignored. Then log2(BLOCK_WORDS) word offset, then log2(SETS) index. Remaining upper bits are the tag.
- Per frame: valid, dirty, tag, BLOCK_WORDS data words. Per set: victim pointer of log2(WAYS) bits.
- Reset:
  - All valid, dirty and victim pointers clear.
  - All outputs 0, hit counter 0, state IDLE.
  - Reset mid-operation abandons any memory access at that edge.
- States: IDLE, WB, FETCH, FLUSH, FLUSH_WB, HITCNT_WR (optional), DONE.
- IDLE, lookup:
  - dhit is combinational: (dmemREN|dmemWEN) & any way valid with matching tag.
  - Read hit: dmemload = addressed word, same cycle (0-cycle hit latency).
  - Write hit: word written and dirty set at the edge.
  - dmemREN and dmemWEN both high: treated as a write.
- IDLE, miss: select the frame at the victim pointer.
  - Victim valid & dirty: go to WB.
  - Otherwise: go to FETCH.
  - Set miss_pend.
- WB:
  - For w = 0..BLOCK_WORDS-1: dWEN=1, daddr = {victim tag, index, w, 2'b00}, dstore = word w.
  - Counter advances on a cycle with dwait=0.
  - After the last word: clear dirty, go to FETCH.
- FETCH:
  - For w = 0..BLOCK_WORDS-1: dREN=1, daddr = {req tag, index, w, 2'b00}.
  - Latch dload into word w when dwait=0.
  - After the last word: set valid, write tag, clear dirty, advance the victim pointer (mod WAYS), return to IDLE. The retried lookup then hits.
- dhit is 0 in every state except IDLE.
- Halt / flush:
  - halt sampled in IDLE takes priority over any request: go to FLUSH.
  - FLUSH scans frames in (set, way) order from (0,0).
  - Valid & dirty frame: enter FLUSH_WB, write back its words exactly as WB does, clear dirty, resume the scan.
  - Clean frames cost 1 cycle each.
  - After the last frame: go to HITCNT_WR if the feature is compiled in, else DONE.
- DONE: flushed=1, held until RST. No memory requests; dhit=0. halt deasserting has no effect.
- Only one of dREN/dWEN is ever high in a cycle. daddr, dstore and the request stay stable while dwait=1.

Optional Feature:
- Macro: DCACHE_HITCNT_EN.
- Compiled in:
  - 32-bit counter increments on each dhit with miss_pend=0. A dhit with miss_pend=1 clears miss_pend without counting.
  - Counter wraps at 2^32.
  - After the flush scan, HITCNT_WR drives dWEN=1, daddr=HITCNT_ADDR, dstore=count until dwait=0, then goes to DONE.
- Compiled out: no counter, no miss_pend; FLUSH goes straight to DONE.

Test Plan:
- Reset, then read 0x40 with memory word 0x40=0xDEADBEEF, dwait=1 for 2 cycles per access -> 2 dREN words at 0x40 and 0x44, then dhit=1 with dmemload=0xDEADBEEF; a second read of 0x44 hits in 0 cycles.
- Write hit 0x40 ← 0x12345678, then 3 distinct tags mapping to set 0 (0x000, 0x040, 0x080, 0x0C0 with defaults) -> third miss evicts the dirty 0x40 block: dWEN at 0x40=0x12345678 and 0x44, then fetch.
- Two ways filled in a set, third tag in the same set -> way 0 replaced; next conflicting tag replaces way 1 (round-robin).
- Dirty blocks in sets 1 and 7, assert halt -> exactly 4 dWEN word writes in ascending set order, then flushed=1 sticky; requests ignored afterward.
- DCACHE_HITCNT_EN, sequence of 2 misses + 5 clean hits, halt -> final write to 0x3100 with dstore=5 before flushed.
- RST asserted during FETCH with dwait=1 -> next cycle dREN=0, all blocks invalid, previously-fetching address misses again.

Source files
------------

// File: rtl/dcache_assoc.sv
// dcache_assoc: parametrised write-back, write-allocate set-associative data cache with halt-driven flush.
// Define DCACHE_HITCNT_EN to count clean hits and store the count at HITCNT_ADDR after the flush.
//
// state     | meaning
// IDLE      | lookup; hits served combinationally, misses pick the victim frame
// WB        | write the dirty victim block back, one word per completed access
// FETCH     | read the requested block into the victim frame
// FLUSH     | scan frames in (set, way) order looking for dirty blocks
// FLUSH_WB  | write back the dirty frame found by the scan
// HITCNT_WR | store the hit counter at HITCNT_ADDR
// DONE      | flush complete, held until reset
module dcache_assoc #(
    parameter int          SETS        = 8,
    parameter int          WAYS        = 2,
    parameter int          BLOCK_WORDS = 2,
    parameter logic [31:0] HITCNT_ADDR = 32'h00003100
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);
    localparam int OW  = $clog2(BLOCK_WORDS);
    localparam int OWX = (OW > 0) ? OW : 1;
    localparam int IW  = $clog2(SETS);
    localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TW  = 30 - OW - IW;

    typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, FLUSH_WB, HITCNT_WR, DONE} state_t;
`ifdef DCACHE_HITCNT_EN
    localparam state_t SCAN_END = HITCNT_WR;
`else
    localparam state_t SCAN_END = DONE;
`endif

    state_t          r_state;
    logic            r_valid [SETS][WAYS];
    logic            r_dirty [SETS][WAYS];
    logic [TW-1:0]   r_tag   [SETS][WAYS];
    logic [31:0]     r_data  [SETS][WAYS][BLOCK_WORDS];
    logic [WW-1:0]   r_vptr  [SETS];
    logic [IW-1:0]   r_set;
    logic [WW-1:0]   r_way;
    logic [OWX-1:0]  r_cnt;
    logic [TW-1:0]   r_tag_req;

    logic [TW-1:0]   w_tag;
    logic [IW-1:0]   w_idx;
    logic [OWX-1:0]  w_off;
    logic            w_req;
    logic            w_hit;
    logic [WW-1:0]   w_hit_way;
    logic [WW-1:0]   w_vic;
    logic            w_last_word;
    logic            w_last_frame;
    logic [31:0]     w_hitcnt;

    function automatic logic [31:0] f_addr(input logic [TW-1:0] t, input logic [IW-1:0] s,
                                           input logic [OWX-1:0] w);
        return (32'(t) << (2 + OW + IW)) | (32'(s) << (2 + OW)) | (32'(w) << 2);
    endfunction

    assign w_tag        = dmemaddr[31 -: TW];
    assign w_idx        = dmemaddr[2+OW +: IW];
    assign w_off        = OWX'((dmemaddr >> 2) & 32'(BLOCK_WORDS - 1));
    assign w_req        = dmemREN | dmemWEN;
    assign w_vic        = r_vptr[w_idx];
    assign w_last_word  = (r_cnt == OWX'(BLOCK_WORDS - 1));
    assign w_last_frame = (r_set == IW'(SETS - 1)) && (r_way == WW'(WAYS - 1));

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (r_valid[w_idx][i] && (r_tag[w_idx][i] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WW'(i);
            end
        end
    end

    // halt wins over a request in IDLE, so a request seen alongside halt is not acknowledged
    assign dhit     = (r_state == IDLE) && !halt && w_req && w_hit;
    assign dmemload = dhit ? r_data[w_idx][w_hit_way][w_off] : 32'd0;
    assign flushed  = (r_state == DONE);

    always_comb begin
        dREN   = 1'b0;
        dWEN   = 1'b0;
        daddr  = 32'd0;
        dstore = 32'd0;
        case (r_state)
            WB, FLUSH_WB: begin
                dWEN   = 1'b1;
                daddr  = f_addr(r_tag[r_set][r_way], r_set, r_cnt);
                dstore = r_data[r_set][r_way][r_cnt];
            end
            FETCH: begin
                dREN  = 1'b1;
                daddr = f_addr(r_tag_req, r_set, r_cnt);
            end
            HITCNT_WR: begin
                dWEN   = 1'b1;
                daddr  = HITCNT_ADDR;
                dstore = w_hitcnt;
            end
            default: ;
        endcase
    end

`ifdef DCACHE_HITCNT_EN
    logic [31:0] r_hitcnt;
    logic        r_miss_pend;
    assign w_hitcnt = r_hitcnt;
`else
    assign w_hitcnt = 32'd0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_set     <= '0;
            r_way     <= '0;
            r_cnt     <= '0;
            r_tag_req <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_vptr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_dirty[s][w] <= 1'b0;
                end
            end
`ifdef DCACHE_HITCNT_EN
            r_hitcnt    <= 32'd0;
            r_miss_pend <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (halt) begin
                        r_state <= FLUSH;
                        r_set   <= '0;
                        r_way   <= '0;
                    end else if (w_req && w_hit) begin
                        if (dmemWEN) begin
                            r_data[w_idx][w_hit_way][w_off] <= dmemstore;
                            r_dirty[w_idx][w_hit_way]       <= 1'b1;
                        end
`ifdef DCACHE_HITCNT_EN
                        if (r_miss_pend) r_miss_pend <= 1'b0;
                        else             r_hitcnt    <= r_hitcnt + 32'd1;
`endif
                    end else if (w_req) begin
                        r_set     <= w_idx;
                        r_way     <= w_vic;
                        r_tag_req <= w_tag;
                        r_cnt     <= '0;
                        r_state   <= (r_valid[w_idx][w_vic] && r_dirty[w_idx][w_vic]) ? WB : FETCH;
`ifdef DCACHE_HITCNT_EN
                        r_miss_pend <= 1'b1;
`endif
                    end
                end
                WB: begin
                    if (!dwait) begin
                        if (w_last_word) begin
                            r_dirty[r_set][r_way] <= 1'b0;
                            r_cnt                 <= '0;
                            r_state               <= FETCH;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (!dwait) begin
                        r_data[r_set][r_way][r_cnt] <= dload;
                        if (w_last_word) begin
                            r_valid[r_set][r_way] <= 1'b1;
                            r_dirty[r_set][r_way] <= 1'b0;
                            r_tag[r_set][r_way]   <= r_tag_req;
                            r_vptr[r_set]         <= (r_vptr[r_set] == WW'(WAYS - 1)) ? '0 : r_vptr[r_set] + 1'b1;
                            r_cnt                 <= '0;
                            r_state               <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (r_valid[r_set][r_way] && r_dirty[r_set][r_way]) begin
                        r_cnt   <= '0;
                        r_state <= FLUSH_WB;
                    end else if (w_last_frame) begin
                        r_state <= SCAN_END;
                    end else if (r_way == WW'(WAYS - 1)) begin
                        r_way <= '0;
                        r_set <= r_set + 1'b1;
                    end else begin
                        r_way <= r_way + 1'b1;
                    end
                end
                FLUSH_WB: begin
                    // returning to FLUSH re-examines the now-clean frame, which then advances the scan
                    if (!dwait) begin
                        if (w_last_word) begin
                            r_dirty[r_set][r_way] <= 1'b0;
                            r_cnt                 <= '0;
                            r_state               <= FLUSH;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                HITCNT_WR: begin
                    if (!dwait) r_state <= DONE;
                end
                DONE:    r_state <= DONE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_assoc.sv
// Bench for dcache_assoc (default shape): random traffic against a golden memory and a set/way occupancy model.
`timescale 1ns/1ps
module tb_dcache_assoc;
    logic        CLK = 1'b0, RST = 1'b1, halt = 1'b0, dmemREN = 1'b0, dmemWEN = 1'b0;
    logic [31:0] dmemaddr = 32'd0, dmemstore = 32'd0, dload = 32'd0;
    logic        dwait = 1'b0;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;

    int n_checks = 0, n_fail = 0;

    dcache_assoc dut (
        .CLK(CLK), .RST(RST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
        .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] mem  [int unsigned];
    logic [31:0] gold [int unsigned];

    function automatic logic [31:0] init_val(input int unsigned a);
        return (a == 32'h40) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h0BADF00D);
    endfunction
    function automatic logic [31:0] mem_rd(input int unsigned a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction
    function automatic logic [31:0] gold_rd(input int unsigned a);
        return gold.exists(a) ? gold[a] : init_val(a);
    endfunction

    // memory controller: random 0..2 wait cycles per access, optional indefinite stall
    logic          force_wait = 1'b0, busy = 1'b0, s_wen = 1'b0;
    int            waits = 0, n_rd = 0, n_wr = 0;
    logic [31:0]   s_addr = 32'd0, s_data = 32'd0;
    logic [31:0]   wr_log[$], rd_log[$];

    always @(negedge CLK) begin
        if (RST) begin
            busy  = 1'b0;
            waits = 0;
            dwait = 1'b0;
        end else if (dREN || dWEN) begin
            if (!busy) begin
                busy   = 1'b1;
                waits  = $urandom_range(0, 2);
                s_wen  = dWEN;
                s_addr = daddr;
                s_data = dstore;
            end
            dload = mem_rd(daddr);
            if (force_wait || waits > 0) begin
                dwait = 1'b1;
                if (waits > 0) waits--;
            end else begin
                dwait = 1'b0;
                busy  = 1'b0;
                chk("mem_onehot", 32'(dREN & dWEN), 32'd0);
                chk("mem_kind_stable", 32'(dWEN), 32'(s_wen));
                chk("mem_addr_stable", daddr, s_addr);
                if (dWEN) begin
                    chk("mem_data_stable", dstore, s_data);
                    mem[daddr] = dstore;
                    wr_log.push_back(daddr);
                    n_wr++;
                end else begin
                    rd_log.push_back(daddr);
                    n_rd++;
                end
            end
        end else begin
            dwait = 1'($urandom_range(0, 1));
        end
    end

    // occupancy model: 8 sets x 2 ways, 2-word blocks, round-robin victim per set
    bit          m_valid [8][2];
    bit          m_dirty [8][2];
    int unsigned m_tag   [8][2];
    int          m_ptr   [8];
    int          m_hits = 0;

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_tag[s][w]   = 0;
            end
        end
        m_hits = 0;
    endtask

    function automatic bit model_hit(input int unsigned a);
        int s = int'((a >> 3) % 8);
        for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_tag[s][w] == (a >> 6)) return 1;
        return 0;
    endfunction

    task automatic req(input bit wr, input int unsigned a, input logic [31:0] d);
        int s, way, exp_wb, rd0, wr0;
        int unsigned t;
        bit hit, seen;
        s = int'((a >> 3) % 8);
        t = a >> 6;
        hit = 0;
        way = 0;
        for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) begin hit = 1; way = w; end
        exp_wb = 0;
        if (!hit) begin
            way = m_ptr[s];
            if (m_valid[s][way] && m_dirty[s][way]) exp_wb = 2;
        end
        @(negedge CLK);
        rd0 = n_rd;
        wr0 = n_wr;
        dmemREN = !wr; dmemWEN = wr; dmemaddr = a; dmemstore = d;
        #1;
        chk("hit_first", 32'(dhit), 32'(hit));
        seen = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (dhit) begin seen = 1; break; end
            @(negedge CLK); #1;
        end
        chk("hit_seen", 32'(seen), 32'd1);
        if (!wr) chk("load_data", dmemload, gold_rd(a));
        @(posedge CLK);
        chk("wb_words", 32'(n_wr - wr0), 32'(exp_wb));
        chk("fetch_words", 32'(n_rd - rd0), hit ? 32'd0 : 32'd2);
        if (wr) gold[a] = d;
        if (hit) m_hits++;
        else begin
            m_valid[s][way] = 1;
            m_dirty[s][way] = 0;
            m_tag[s][way]   = t;
            m_ptr[s]        = (m_ptr[s] + 1) % 2;
        end
        if (wr) m_dirty[s][way] = 1;
    endtask

    int unsigned a_rst;
    logic [31:0] exp_fl[$];
    int          rd0, wr0;
    bit          seen;

    initial begin
        model_reset();
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_dhit", 32'(dhit), 32'd0);
        chk("rst_dren", 32'(dREN), 32'd0);
        chk("rst_dwen", 32'(dWEN), 32'd0);
        chk("rst_flushed", 32'(flushed), 32'd0);
        chk("rst_daddr", daddr, 32'd0);
        chk("rst_dstore", dstore, 32'd0);
        chk("rst_dmemload", dmemload, 32'd0);
        RST = 1'b0;

        // cold read miss fetches both words of the block
        rd_log.delete();
        req(0, 32'h40, 32'd0);
        chk("fetch_cnt", 32'(rd_log.size()), 32'd2);
        if (rd_log.size() >= 2) begin
            chk("fetch_addr0", rd_log[0], 32'h40);
            chk("fetch_addr1", rd_log[1], 32'h44);
        end
        req(0, 32'h44, 32'd0);

        // dirty eviction and round-robin in set 0
        req(1, 32'h40, 32'h12345678);
        req(0, 32'h000, 32'd0);
        wr_log.delete();
        req(0, 32'h080, 32'd0);
        chk("evict_cnt", 32'(wr_log.size()), 32'd2);
        if (wr_log.size() >= 2) begin
            chk("evict_addr0", wr_log[0], 32'h40);
            chk("evict_addr1", wr_log[1], 32'h44);
        end
        chk("evict_data", mem_rd(32'h40), 32'h12345678);
        req(0, 32'h0C0, 32'd0);
        req(0, 32'h080, 32'd0);
        req(0, 32'h000, 32'd0);

        repeat (300) req(1'($urandom_range(0, 1)), 4 * $urandom_range(0, 255), $urandom);

        // reset in the middle of a stalled fetch
        a_rst = 32'h0;
        for (int t = 0; t < 16; t++)
            if (!model_hit(32'(t) << 6)) a_rst = 32'(t) << 6;
        @(negedge CLK);
        dmemREN = 1'b1; dmemWEN = 1'b0; dmemaddr = a_rst;
        seen = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            #1;
            if (dREN) begin seen = 1; break; end
            @(negedge CLK);
        end
        chk("rst_fetch_started", 32'(seen), 32'd1);
        force_wait = 1'b1;
        RST = 1'b1; dmemREN = 1'b0;
        @(negedge CLK); #1;
        chk("rst_mid_dren", 32'(dREN), 32'd0);
        chk("rst_mid_dwen", 32'(dWEN), 32'd0);
        RST = 1'b0;
        force_wait = 1'b0;
        model_reset();
        gold = mem;
        req(0, a_rst, 32'd0);

        // dirty blocks in sets 1 and 7, a few clean hits, then flush
        req(1, 32'h08, 32'hA5A50001);
        req(1, 32'h38, 32'hA5A50007);
        req(0, 32'h08, 32'd0);
        req(0, 32'h0C, 32'd0);
        req(0, 32'h38, 32'd0);
        req(0, 32'h3C, 32'd0);
        req(1, 32'h0C, 32'hC0FFEE00);
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 2; w++)
                if (m_valid[s][w] && m_dirty[s][w]) begin
                    exp_fl.push_back((m_tag[s][w] << 6) | 32'(s << 3));
                    exp_fl.push_back((m_tag[s][w] << 6) | 32'(s << 3) | 32'd4);
                end
`ifdef DCACHE_HITCNT_EN
        exp_fl.push_back(32'h00003100);
`endif
        wr_log.delete();
        @(negedge CLK);
        dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge CLK); #1;
            if (flushed) begin seen = 1; break; end
        end
        chk("flush_done", 32'(seen), 32'd1);
        halt = 1'b0;
        chk("flush_wr_cnt", 32'(wr_log.size()), 32'(exp_fl.size()));
        for (int i = 0; i < exp_fl.size() && i < wr_log.size(); i++)
            chk("flush_wr_addr", wr_log[i], exp_fl[i]);
`ifdef DCACHE_HITCNT_EN
        chk("hitcnt_value", mem_rd(32'h00003100), 32'(m_hits));
`endif

        // flushed is sticky and requests are ignored
        rd0 = n_rd; wr0 = n_wr;
        dmemREN = 1'b1; dmemaddr = 32'h08;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK); #1;
            chk("sticky_flushed", 32'(flushed), 32'd1);
            chk("sticky_dhit", 32'(dhit), 32'd0);
        end
        dmemREN = 1'b0;
        chk("post_flush_rd", 32'(n_rd - rd0), 32'd0);
        chk("post_flush_wr", 32'(n_wr - wr0), 32'd0);

        foreach (gold[k]) chk("mem_vs_gold", mem_rd(k), gold[k]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
